// File: rtl/multicycle_main_control_if.sv
// Control bus between the multicycle main control FSM (master) and the datapath (slave).
// IllegalOp is present only when ILLEGAL_OP_TRAP_EN is defined.
interface multicycle_main_control_if;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUop;
    logic [1:0] PCSource;
    logic [3:0] State;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       IllegalOp;
`endif

    modport master (
        input  Op, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource,
`ifdef ILLEGAL_OP_TRAP_EN
               IllegalOp,
`endif
               State
    );

    modport slave (
        output Op, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource,
`ifdef ILLEGAL_OP_TRAP_EN
               IllegalOp,
`endif
               State
    );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM of the 32-bit multicycle datapath: sequences fetch/decode/execute/mem/writeback.
// Define ILLEGAL_OP_TRAP_EN to trap undefined opcodes in a TRAP state that raises IllegalOp.
module multicycle_main_control (
    input  logic                              clk,
    input  logic                              reset,
    multicycle_main_control_if.master         ctrl
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
`ifdef ILLEGAL_OP_TRAP_EN
        TRAP   = 4'd12,
`endif
        JUMP   = 4'd11
    } state_e;

    state_e state_q;
    state_e state_d;

    // Next-state logic; Op is looked at only in DECODE and MEMADR.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = ctrl.MemReady ? DECODE : FETCH;
            DECODE: begin
                case (ctrl.Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      state_d = TRAP;
`else
                    default:      state_d = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                if (ctrl.Op == OP_LW)      state_d = MEMRD;
                else if (ctrl.Op == OP_SW) state_d = MEMWR;
                else                       state_d = FETCH;
            end
            MEMRD:  state_d = ctrl.MemReady ? MEMWB : MEMRD;
            MEMWB:  state_d = FETCH;
            MEMWR:  state_d = ctrl.MemReady ? FETCH : MEMWR;
            EXEC:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            ADDIEX: state_d = ADDIWB;
            ADDIWB: state_d = FETCH;
            JUMP:   state_d = FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
            TRAP:   state_d = TRAP;
`endif
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignment for sequential state avoids read/write races between flops.
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Outputs decode from the state; MemReady qualifies only the FETCH writes.
    always_comb begin
        ctrl.PCWrite     = 1'b0;
        ctrl.PCWriteCond = 1'b0;
        ctrl.IorD        = 1'b0;
        ctrl.MemRead     = 1'b0;
        ctrl.MemWrite    = 1'b0;
        ctrl.IRWrite     = 1'b0;
        ctrl.MemtoReg    = 1'b0;
        ctrl.RegDst      = 1'b0;
        ctrl.RegWrite    = 1'b0;
        ctrl.ALUSrcA     = 1'b0;
        ctrl.ALUSrcB     = 2'b00;
        ctrl.ALUop       = 2'b00;
        ctrl.PCSource    = 2'b00;
`ifdef ILLEGAL_OP_TRAP_EN
        ctrl.IllegalOp   = 1'b0;
`endif
        case (state_q)
            FETCH: begin
                ctrl.MemRead = 1'b1;
                ctrl.ALUSrcB = 2'b01;
                ctrl.IRWrite = ctrl.MemReady;
                ctrl.PCWrite = ctrl.MemReady;
            end
            DECODE: ctrl.ALUSrcB = 2'b11;
            MEMADR, ADDIEX: begin
                ctrl.ALUSrcA = 1'b1;
                ctrl.ALUSrcB = 2'b10;
            end
            MEMRD: begin
                ctrl.MemRead = 1'b1;
                ctrl.IorD    = 1'b1;
            end
            MEMWB: begin
                ctrl.RegWrite = 1'b1;
                ctrl.MemtoReg = 1'b1;
            end
            MEMWR: begin
                ctrl.MemWrite = 1'b1;
                ctrl.IorD     = 1'b1;
            end
            EXEC: begin
                ctrl.ALUSrcA = 1'b1;
                ctrl.ALUop   = 2'b10;
            end
            ALUWB: begin
                ctrl.RegWrite = 1'b1;
                ctrl.RegDst   = 1'b1;
            end
            BRANCH: begin
                ctrl.ALUSrcA     = 1'b1;
                ctrl.ALUop       = 2'b01;
                ctrl.PCWriteCond = 1'b1;
                ctrl.PCSource    = 2'b01;
            end
            ADDIWB: ctrl.RegWrite = 1'b1;
            JUMP: begin
                ctrl.PCWrite  = 1'b1;
                ctrl.PCSource = 2'b10;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            TRAP: ctrl.IllegalOp = 1'b1;
`endif
            default: ;
        endcase
    end

    assign ctrl.State = state_q;

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control state machine for the 32-bit multicycle datapath. Consumes the instruction opcode and sequences the fetch/decode/execute/memory/writeback steps.
- Drives all datapath enables and muxes, and produces the 2-bit ALUop that the ALU control decoder turns into the ALU operation.
- Handshakes with the unified instruction/data memory through MemReady.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-if-equal opcode
- OP_ADDI, 6'b001000, add-immediate opcode
- OP_J, 6'b000010, jump opcode

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; forces state FETCH
- Op  input  6  opcode from instruction register bits [31:26]
- MemReady  input  1  memory completes the current read/write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by ALU Zero (beq)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  writeback select: 0 = ALUOut, 1 = MDR
- RegDst  output  1  destination select: 0 = rt, 1 = rd
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- ALUop  output  2  00 = add, 01 = subtract, 10 = decode Funct
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- State  output  4  current state encoding, for debug and verification

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unused and go to FETCH on the next edge.
- Outputs are decoded combinationally from State; only MemReady qualifies any of them. Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
  - IRWrite and PCWrite equal MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00. Next state by Op:
  - LW or SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - any other opcode -> FETCH (instruction dropped)
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Next: LW -> MEMRD, SW -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Waits until MemReady=1, then -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next -> FETCH.
- MEMWR: MemWrite=1, IorD=1. Waits until MemReady=1, then -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10. Next -> ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01. Next -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUop=00. Next -> ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next -> FETCH.
- JUMP: PCWrite=1, PCSource=10. Next -> FETCH.
- Latency with zero wait states, counting edges from FETCH back to FETCH:
  - LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
  - Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Op is sampled only in DECODE and MEMADR; Op changes in other states have no effect.
- Reset asserted in any state, including mid-wait in MEMRD or MEMWR: State=0 immediately, without waiting for a clock edge.
  - Outputs then show the FETCH values: MemRead=1, ALUSrcB=01, all write enables 0 while MemReady=0.
  - On release, the first rising edge evaluates FETCH normally.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- When defined:
  - Adds state TRAP=12 and output IllegalOp (1 bit).
  - An undefined opcode in DECODE goes to TRAP instead of FETCH.
  - TRAP holds every enable at 0 (no PC, memory or register writes), drives IllegalOp=1, and stays there until reset. IllegalOp resets to 0.
- When not defined: no IllegalOp port; undefined opcodes return to FETCH as above.

Test Plan:
- Reset, then release with MemReady=1 and Op=6'b100011 -> State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
- Op=6'b000000 with MemReady=1 -> states 0,1,6,7,0; ALUop=10 in state 6; RegDst=1 and RegWrite=1 in state 7.
- Op=6'b101011 with MemReady held 0 for 3 cycles in MEMWR -> MemWrite=1 and IorD=1 for 4 cycles, RegWrite never 1, then State returns to 0.
- Op=6'b000100 -> states 0,1,8,0; in state 8 PCWriteCond=1, ALUop=01, PCSource=01. Op=6'b000010 -> state 11 with PCWrite=1, PCSource=10.
- Op=6'b111111 -> DECODE then FETCH with no writes. With ILLEGAL_OP_TRAP_EN defined -> State=12, IllegalOp=1 held 10+ cycles, then reset clears it.
- Assert reset asynchronously mid-cycle while in MEMRD (MemReady=0) -> State=0 before the next edge; IRWrite=0 and PCWrite=0 until MemReady=1.
